// File: rtl/spi_sensor_poller.sv
// Periodic multi-channel SPI sensor poller; raises a CPU IRQ when a channel moves by more than Threshold_i.
// Latency: one scan = period count + per channel (select, 1+DataBytes pushes, SPI drain, pops, compare, guard).
// Backpressure: TX pushes stall while SPI_FIFOFull_i=1; RX pops are issued only while SPI_FIFOEmpty_i=0.
// Optional: SPI_POLLER_IRQ_STATUS_EN adds sticky IrqStatus_o with per-bit IrqClear_i.
module spi_sensor_poller #(
    parameter int         Channels  = 2,
    parameter int         DataBytes = 2,
    parameter logic [7:0] ReadCmd   = 8'h50
) (
    input  logic                            Reset_n_i,
    input  logic                            Clk_i,
    input  logic                            Enable_i,
    output logic                            CpuIntr_o,
    output logic [Channels-1:0]             CS_n_o,
    output logic                            SPI_Write_o,
    output logic                            SPI_ReadNext_o,
    output logic [7:0]                      SPI_Data_o,
    input  logic [7:0]                      SPI_Data_i,
    input  logic                            SPI_FIFOFull_i,
    input  logic                            SPI_FIFOEmpty_i,
    input  logic                            SPI_Transmission_i,
    output logic                            SPI_CPOL_o,
    output logic                            SPI_CPHA_o,
    output logic                            SPI_LSBFE_o,
    input  logic [15:0]                     SPICounterPreset_i,
    input  logic [31:0]                     PeriodCounterPreset_i,
    input  logic [15:0]                     Threshold_i,
    output logic [Channels*8*DataBytes-1:0] SensorValue_o,
`ifdef SPI_POLLER_IRQ_STATUS_EN
    input  logic [Channels-1:0]             IrqClear_i,
    output logic [Channels-1:0]             IrqStatus_o,
`endif
    output logic [Channels-1:0]             IrqChannels_o
);
    localparam int         VW       = 8 * DataBytes;
    localparam logic [1:0] LastCh   = 2'(Channels - 1);
    localparam logic [1:0] LastByte = 2'(DataBytes);

    typedef enum logic [3:0] {
        ST_DISABLED, ST_PERIOD, ST_SELECT, ST_SEND, ST_DRAIN,
        ST_READ, ST_COMPARE, ST_GUARD, ST_FLUSH
    } state_t;

    state_t              state;
    logic [31:0]         cnt;
    logic [1:0]          ch;
    logic [1:0]          byte_cnt;
    logic [VW-1:0]       value_q;
    logic [Channels-1:0] first;
    logic [Channels-1:0] fire;

    logic [Channels-1:0] ch_onehot;
    logic [VW-1:0]       value_next;
    logic [VW-1:0]       stored;
    logic [VW-1:0]       thr;
    logic [VW:0]         delta;

    assign SPI_CPOL_o  = 1'b1;
    assign SPI_CPHA_o  = 1'b1;
    assign SPI_LSBFE_o = 1'b0;

    assign ch_onehot = Channels'(1) << ch;
    assign thr       = VW'(Threshold_i);

    // Result bytes arrive MSB first, so each new byte shifts in at the bottom.
    if (VW > 8) begin : g_shift
        assign value_next = {value_q[VW-9:0], SPI_Data_i};
    end else begin : g_byte
        assign value_next = SPI_Data_i;
    end

    always_comb begin
        stored = '0;
        for (int k = 0; k < Channels; k++)
            if (ch == 2'(k)) stored = SensorValue_o[k*VW +: VW];
    end

    assign delta = (value_q >= stored) ? {1'b0, value_q - stored} : {1'b0, stored - value_q};

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            state          <= ST_DISABLED;
            cnt            <= '0;
            ch             <= '0;
            byte_cnt       <= '0;
            value_q        <= '0;
            first          <= '0;
            fire           <= '0;
            CS_n_o         <= '1;
            SPI_Write_o    <= 1'b0;
            SPI_ReadNext_o <= 1'b0;
            SPI_Data_o     <= '0;
            CpuIntr_o      <= 1'b0;
            SensorValue_o  <= '0;
            IrqChannels_o  <= '0;
        end else begin
            SPI_Write_o    <= 1'b0;
            SPI_ReadNext_o <= 1'b0;
            CpuIntr_o      <= 1'b0;
            case (state)
                ST_DISABLED: begin
                    CS_n_o <= '1;
                    if (Enable_i) begin
                        first <= '1;
                        fire  <= '0;
                        cnt   <= PeriodCounterPreset_i;
                        state <= ST_PERIOD;
                    end
                end
                ST_PERIOD: begin
                    if (!Enable_i)         state <= ST_DISABLED;
                    else if (cnt == '0) begin
                        ch    <= '0;
                        state <= ST_SELECT;
                    end else               cnt <= cnt - 32'd1;
                end
                ST_SELECT: begin
                    if (!Enable_i) begin
                        CS_n_o <= '1;
                        state  <= ST_FLUSH;
                    end else begin
                        CS_n_o   <= ~ch_onehot;
                        byte_cnt <= '0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!Enable_i) begin
                        CS_n_o <= '1;
                        state  <= ST_FLUSH;
                    end else if (!SPI_FIFOFull_i) begin
                        SPI_Write_o <= 1'b1;
                        SPI_Data_o  <= (byte_cnt == 2'd0) ? ReadCmd : 8'hFF;
                        if (byte_cnt == LastByte) begin
                            byte_cnt <= '0;
                            state    <= ST_DRAIN;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!Enable_i) begin
                        CS_n_o <= '1;
                        state  <= ST_FLUSH;
                    end else if (!SPI_Transmission_i) begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!Enable_i) begin
                        CS_n_o <= '1;
                        state  <= ST_FLUSH;
                    end else if (!SPI_ReadNext_o && !SPI_FIFOEmpty_i) begin
                        // Skip the cycle after a pop: FIFO head/empty still reflect the old entry.
                        SPI_ReadNext_o <= 1'b1;
                        if (byte_cnt != 2'd0) value_q <= value_next;
                        if (byte_cnt == LastByte) begin
                            CS_n_o <= '1;
                            state  <= ST_COMPARE;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end
                end
                ST_COMPARE: begin
                    if ((first & ch_onehot) != '0 || delta > {1'b0, thr}) begin
                        for (int k = 0; k < Channels; k++)
                            if (ch == 2'(k)) SensorValue_o[k*VW +: VW] <= value_q;
                        fire  <= fire | ch_onehot;
                        first <= first & ~ch_onehot;
                    end
                    cnt   <= {16'd0, SPICounterPreset_i};
                    state <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (!Enable_i)          state <= ST_DISABLED;
                    else if (cnt != '0)     cnt <= cnt - 32'd1;
                    else if (ch != LastCh) begin
                        ch    <= ch + 2'd1;
                        state <= ST_SELECT;
                    end else begin
                        if (fire != '0) begin
                            CpuIntr_o     <= 1'b1;
                            IrqChannels_o <= fire;
                        end
                        fire  <= '0;
                        cnt   <= PeriodCounterPreset_i;
                        state <= ST_PERIOD;
                    end
                end
                ST_FLUSH: begin
                    if (!SPI_Transmission_i && !SPI_ReadNext_o) begin
                        if (!SPI_FIFOEmpty_i) SPI_ReadNext_o <= 1'b1;
                        else                  state <= ST_DISABLED;
                    end
                end
                default: state <= ST_DISABLED;
            endcase
        end
    end

`ifdef SPI_POLLER_IRQ_STATUS_EN
    logic scan_end;

    // Same cycle that loads IrqChannels_o; a new fire beats a simultaneous clear.
    assign scan_end = (state == ST_GUARD) && Enable_i && (cnt == '0) && (ch == LastCh);

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) IrqStatus_o <= '0;
        else            IrqStatus_o <= (IrqStatus_o & ~IrqClear_i) | (scan_end ? fire : '0);
    end
`endif

endmodule

// File: tb/tb_spi_sensor_poller.sv
// Directed bench for spi_sensor_poller with a behavioural SPI master (TX/RX queues, 4-cycle bytes).
module tb_spi_sensor_poller;
    logic        Clk_i = 1'b0;
    logic        Reset_n_i = 1'b0;
    logic        Enable_i = 1'b0;
    logic        CpuIntr_o;
    logic [1:0]  CS_n_o;
    logic        SPI_Write_o, SPI_ReadNext_o;
    logic [7:0]  SPI_Data_o;
    logic [7:0]  SPI_Data_i = 8'h00;
    logic        SPI_FIFOFull_i = 1'b0;
    logic        SPI_FIFOEmpty_i = 1'b1;
    logic        SPI_Transmission_i = 1'b0;
    logic        SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o;
    logic [15:0] SPICounterPreset_i = 16'd4;
    logic [31:0] PeriodCounterPreset_i = 32'd100;
    logic [15:0] Threshold_i = 16'd16;
    logic [31:0] SensorValue_o;
    logic [1:0]  IrqChannels_o;
`ifdef SPI_POLLER_IRQ_STATUS_EN
    logic [1:0]  IrqClear_i = 2'b00;
    logic [1:0]  IrqStatus_o;
`endif

    spi_sensor_poller #(.Channels(2), .DataBytes(2), .ReadCmd(8'h50)) dut (
        .Reset_n_i(Reset_n_i), .Clk_i(Clk_i), .Enable_i(Enable_i), .CpuIntr_o(CpuIntr_o),
        .CS_n_o(CS_n_o), .SPI_Write_o(SPI_Write_o), .SPI_ReadNext_o(SPI_ReadNext_o),
        .SPI_Data_o(SPI_Data_o), .SPI_Data_i(SPI_Data_i), .SPI_FIFOFull_i(SPI_FIFOFull_i),
        .SPI_FIFOEmpty_i(SPI_FIFOEmpty_i), .SPI_Transmission_i(SPI_Transmission_i),
        .SPI_CPOL_o(SPI_CPOL_o), .SPI_CPHA_o(SPI_CPHA_o), .SPI_LSBFE_o(SPI_LSBFE_o),
        .SPICounterPreset_i(SPICounterPreset_i), .PeriodCounterPreset_i(PeriodCounterPreset_i),
        .Threshold_i(Threshold_i), .SensorValue_o(SensorValue_o),
`ifdef SPI_POLLER_IRQ_STATUS_EN
        .IrqClear_i(IrqClear_i), .IrqStatus_o(IrqStatus_o),
`endif
        .IrqChannels_o(IrqChannels_o)
    );

    always #5 Clk_i = ~Clk_i;

    // SPI master model state
    logic [7:0]  tx_q[$], rx_q[$], wr_log[$];
    logic [1:0]  cs_vals[$];
    int          cs_lens[$];
    logic [1:0]  cs_prev = 2'b11;
    int          cs_run = 0, scan_cnt = 0, intr_cnt = 0, wr_full = 0, both_hi = 0;
    int          busy = 0, bidx = 0;
    logic [7:0]  resp = 8'h00, tmp;
    logic        full_prev = 1'b0;
    logic [15:0] sensor0 = 16'h0C80, sensor1 = 16'h0D00;
    int          errors = 0, checks = 0;

    function automatic logic [7:0] sensor_byte(input int idx, input logic [1:0] cs,
                                               input logic [15:0] s0, input logic [15:0] s1);
        logic [15:0] v;
        v = (cs == 2'b01) ? s1 : s0;
        if (idx == 0)      return 8'hA5;
        else if (idx == 1) return v[15:8];
        else               return v[7:0];
    endfunction

    always @(posedge Clk_i) full_prev <= SPI_FIFOFull_i;

    always @(negedge Clk_i) begin
        if (CS_n_o !== cs_prev) begin
            if (cs_prev == 2'b01 && CS_n_o == 2'b11) scan_cnt++;
            cs_vals.push_back(cs_prev);
            cs_lens.push_back(cs_run);
            cs_prev = CS_n_o;
            cs_run  = 1;
        end else begin
            cs_run++;
        end
        if (!Reset_n_i) begin
            tx_q.delete();
            rx_q.delete();
            busy = 0;
            bidx = 0;
        end else begin
            if (SPI_Write_o) begin
                tx_q.push_back(SPI_Data_o);
                wr_log.push_back(SPI_Data_o);
                if (full_prev) wr_full++;
            end
            if (SPI_Write_o && SPI_ReadNext_o) both_hi++;
            if (SPI_ReadNext_o && rx_q.size() > 0) tmp = rx_q.pop_front();
            if (CpuIntr_o) intr_cnt++;
            if (busy > 0) begin
                busy--;
                if (busy == 0) rx_q.push_back(resp);
            end else if (tx_q.size() > 0) begin
                tmp  = tx_q.pop_front();
                resp = sensor_byte(bidx, CS_n_o, sensor0, sensor1);
                bidx++;
                busy = 3;
            end
            if (CS_n_o == 2'b11) bidx = 0;
        end
        SPI_Transmission_i = (busy > 0) || (tx_q.size() > 0);
        SPI_FIFOEmpty_i    = (rx_q.size() == 0);
        SPI_Data_i         = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_intr(input string tag);
        int n = 0;
        while (CpuIntr_o !== 1'b1 && n < 2000) begin @(negedge Clk_i); n++; end
        check(tag, {31'd0, CpuIntr_o}, 32'd1);
    endtask

    task automatic wait_cs_low(input string tag);
        int n = 0;
        while (CS_n_o === 2'b11 && n < 2000) begin @(negedge Clk_i); n++; end
        check(tag, {31'd0, (CS_n_o !== 2'b11)}, 32'd1);
    endtask

    task automatic wait_scan(input string tag);
        int n = 0;
        int s = scan_cnt;
        while (scan_cnt == s && n < 2000) begin @(negedge Clk_i); n++; end
        check(tag, {31'd0, (scan_cnt != s)}, 32'd1);
    endtask

    logic [7:0] exp_wr [6] = '{8'h50, 8'hFF, 8'hFF, 8'h50, 8'hFF, 8'hFF};
    int         cs_seen;

    initial begin
        repeat (3) @(negedge Clk_i);
        check("rst_cs_n", {30'd0, CS_n_o}, 32'h3);
        check("rst_intr", {31'd0, CpuIntr_o}, 32'd0);
        check("rst_write", {31'd0, SPI_Write_o}, 32'd0);
        check("rst_readnext", {31'd0, SPI_ReadNext_o}, 32'd0);
        check("rst_data", {24'd0, SPI_Data_o}, 32'd0);
        check("rst_value", SensorValue_o, 32'd0);
        check("rst_irqch", {30'd0, IrqChannels_o}, 32'd0);
        check("spi_mode", {29'd0, SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o}, 32'b110);
`ifdef SPI_POLLER_IRQ_STATUS_EN
        check("rst_irqstat", {30'd0, IrqStatus_o}, 32'd0);
`endif
        Reset_n_i = 1'b1;
        Enable_i  = 1'b1;

        // Scan 1: first values always reported
        wait_intr("s1_irq");
        check("s1_irqch", {30'd0, IrqChannels_o}, 32'h3);
        check("s1_value", SensorValue_o, 32'h0D00_0C80);
        sensor0 = 16'h0C88;
        sensor1 = 16'h0D11;
        repeat (3) @(negedge Clk_i);
        check("s1_intr_cnt", intr_cnt, 1);
        check("s1_cs_sel0", {30'd0, cs_vals[1]}, 32'h2);
        check("s1_cs_guard", {30'd0, cs_vals[2]}, 32'h3);
        check("s1_guard_len", {31'd0, (cs_lens[2] >= 4)}, 32'd1);
        check("s1_cs_sel1", {30'd0, cs_vals[3]}, 32'h1);
        check("s1_wr_cnt", wr_log.size(), 6);
        check("s1_wr_cmd", {24'd0, wr_log[0]}, 32'h50);
        wr_log.delete();

        // Scan 2: ch0 d=8 held, ch1 d=17 reported
        wait_intr("s2_irq");
        check("s2_irqch", {30'd0, IrqChannels_o}, 32'h2);
        check("s2_value", SensorValue_o, 32'h0D11_0C80);
        sensor0 = 16'h0C90;
        sensor1 = 16'h0D11;
        repeat (3) @(negedge Clk_i);
        check("s2_intr_cnt", intr_cnt, 2);

        // Scan 3: ch0 d=Threshold, ch1 equal -> no IRQ
        wait_scan("s3_scan");
        repeat (15) @(negedge Clk_i);
        check("s3_intr_cnt", intr_cnt, 2);
        check("s3_value", SensorValue_o, 32'h0D11_0C80);
        sensor0 = 16'h0C91;
        sensor1 = 16'h0D00;

        // Scan 4: d=Threshold+1 in both directions
        wait_intr("s4_irq");
        check("s4_irqch", {30'd0, IrqChannels_o}, 32'h3);
        check("s4_value", SensorValue_o, 32'h0D00_0C91);
        sensor0 = 16'h1234;
        sensor1 = 16'h0E00;
        repeat (3) @(negedge Clk_i);
        check("s4_intr_cnt", intr_cnt, 3);
        wr_log.delete();
`ifdef SPI_POLLER_IRQ_STATUS_EN
        check("s4_irqstat", {30'd0, IrqStatus_o}, 32'h3);
        IrqClear_i = 2'b10;
`endif

        // Scan 5: TX FIFO full for 10 cycles at the start of ch0 Send
        wait_cs_low("s5_cs_low");
        SPI_FIFOFull_i = 1'b1;
        repeat (10) @(negedge Clk_i);
        check("s5_no_push_full", wr_log.size(), 0);
        SPI_FIFOFull_i = 1'b0;
`ifdef SPI_POLLER_IRQ_STATUS_EN
        check("s5_irqstat_clr", {30'd0, IrqStatus_o}, 32'h1);
`endif
        wait_intr("s5_irq");
`ifdef SPI_POLLER_IRQ_STATUS_EN
        check("s5_set_wins", {30'd0, IrqStatus_o}, 32'h3);
        IrqClear_i = 2'b00;
`endif
        check("s5_irqch", {30'd0, IrqChannels_o}, 32'h3);
        check("s5_value", SensorValue_o, 32'h0E00_1234);
        sensor0 = 16'h5555;
        sensor1 = 16'h6666;
        repeat (3) @(negedge Clk_i);
        check("s5_wr_cnt", wr_log.size(), 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("s5_wr_%0d", i), {24'd0, wr_log[i]}, {24'd0, exp_wr[i]});
        check("s5_wr_while_full", wr_full, 0);
        check("s5_intr_cnt", intr_cnt, 4);

        // Scan 6: drop Enable_i while the SPI master is still shifting (Drain)
        wait_cs_low("s6_cs_low");
        repeat (5) @(negedge Clk_i);
        check("s6_in_drain", {31'd0, SPI_Transmission_i}, 32'd1);
        Enable_i = 1'b0;
        @(negedge Clk_i);
        check("s6_cs_high", {30'd0, CS_n_o}, 32'h3);
        repeat (60) @(negedge Clk_i);
        check("s6_rx_drained", rx_q.size(), 0);
        check("s6_fifo_empty", {31'd0, SPI_FIFOEmpty_i}, 32'd1);
        check("s6_value_kept", SensorValue_o, 32'h0E00_1234);
        cs_seen = cs_vals.size();
        repeat (300) @(negedge Clk_i);
        check("s6_idle_cs", cs_vals.size(), cs_seen);
        check("s6_idle_cs_n", {30'd0, CS_n_o}, 32'h3);
        check("s6_intr_cnt", intr_cnt, 4);
        check("wr_rd_overlap", both_hi, 0);
        check("wr_while_full", wr_full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_sensor_poller.md
# spi_sensor_poller

Periodic multi-channel SPI sensor poller, the parametrised successor of the single-sensor ADT7310 measurement application. It drives the shared SPI master, selects one of `Channels` sensors per transfer and reads a `DataBytes`-wide result after a fixed read command. Each channel's value is compared with that channel's last reported value, and the CPU is interrupted when the difference exceeds `Threshold_i`. It sits in the reconfigurable module between the SPI master FIFO interface, the sensor chip selects and the CPU IRQ line.

## Interface
- `Channels`, 2: number of sensors and chip selects (1..4).
- `DataBytes`, 2: result bytes per read (1 or 2); VW = 8*DataBytes.
- `ReadCmd`, 8'h50: command byte sent first in every transfer.
- `Reset_n_i`  in  1  asynchronous active-low reset.
- `Clk_i`  in  1  sole clock, rising edge.
- `Enable_i`  in  1  level; 1 = polling active.
- `CpuIntr_o`  out  1  one-cycle IRQ pulse.
- `CS_n_o`  out  Channels  active-low chip selects, one-hot-low.
- `SPI_Write_o`  out  1  push `SPI_Data_o` into TX FIFO.
- `SPI_ReadNext_o`  out  1  pop RX FIFO.
- `SPI_Data_o`  out  8  TX byte.
- `SPI_Data_i`  in  8  RX FIFO head.
- `SPI_FIFOFull_i`, `SPI_FIFOEmpty_i`, `SPI_Transmission_i`  in  1 each  SPI master status.
- `SPI_CPOL_o`=1, `SPI_CPHA_o`=1, `SPI_LSBFE_o`=0  out  1 each  constants.
- `SPICounterPreset_i`  in  16  CS-high guard cycles between channels.
- `PeriodCounterPreset_i`  in  32  idle cycles between scans.
- `Threshold_i`  in  16  change threshold; compared zero-extended/truncated to VW.
- `SensorValue_o`  out  Channels*VW  last reported value per channel; channel k at bits [k*VW +: VW].
- `IrqChannels_o`  out  Channels  channels that fired in the last completed scan.

## Operation
- States: Disabled, Period, Select, Send, Drain, Read, Compare, Guard, Flush.
- Disabled: all CS_n high. On `Enable_i`=1 -> Period and mark every channel "first".
- Period: load the counter with `PeriodCounterPreset_i`, decrement to 0, then -> Select with channel k=0. A preset of 0 gives back-to-back scans.
- Select: drive `CS_n_o[k]`=0 -> Send.
- Send: push `ReadCmd`, then DataBytes bytes of 8'hFF. One `SPI_Write_o` pulse per byte, issued only in cycles where `SPI_FIFOFull_i`=0; the push is stalled otherwise.
- Drain: wait for `SPI_Transmission_i`=0 -> Read.
- Read: pop DataBytes+1 bytes with one `SPI_ReadNext_o` pulse each, only while `SPI_FIFOEmpty_i`=0. Discard the first byte; the rest assemble MSB first into value V. Then raise `CS_n_o[k]` -> Compare.
- Compare, one cycle:
  - d = |V - stored[k]|, computed unsigned at VW+1 bits.
  - If first[k] or d > threshold: stored[k] <= V, set the fire bit k, clear first[k].
  - Otherwise stored[k] is unchanged.
- Guard: count `SPICounterPreset_i` cycles with all CS_n high. Then k+1 -> Select, or after the last channel: if any fire bit is set, pulse `CpuIntr_o` and load `IrqChannels_o`, clear the fire bits, -> Period.
- `Enable_i`=0 in Period or Guard: -> Disabled immediately.
- `Enable_i`=0 in Select/Send/Drain/Read: stop pushing, raise all CS_n, -> Flush.
- Flush: wait for `SPI_Transmission_i`=0, pop until `SPI_FIFOEmpty_i`=1, -> Disabled. Partial data is discarded and `SensorValue_o` is unchanged.

## Timing
- Reset values:
  - `CS_n_o` all 1.
  - `CpuIntr_o`, `SPI_Write_o`, `SPI_ReadNext_o`, `SPI_Data_o`, `SensorValue_o`, `IrqChannels_o` all 0.
  - State Disabled.
- All outputs are registered.
- `SPI_Write_o` and `SPI_ReadNext_o` are never high in the same cycle.
- CS_n falls 1 cycle before the first `SPI_Write_o`.
- `SensorValue_o` updates 1 cycle after Compare.
- `CpuIntr_o` is a 1-cycle pulse coincident with the `IrqChannels_o` update, at most once per scan.
- Reset asserted mid-transfer returns every output to its reset value asynchronously; there is no flush.

## Configuration
- `SPI_POLLER_IRQ_STATUS_EN` defined: adds input `IrqClear_i` (Channels) and output `IrqStatus_o` (Channels, reset 0).
  - Fire bits OR into `IrqStatus_o` at scan end and stay sticky.
  - A bit clears when the matching `IrqClear_i` bit is 1. Set wins over clear in the same cycle.
- Undefined: these ports are absent and only `IrqChannels_o` reports.

## Test plan
- Channels=2, Period=100, Guard=4, sensor returns 16'h0C80/16'h0D00 -> first scan: `SensorValue_o`={16'h0D00,16'h0C80}, `IrqChannels_o`=2'b11, one `CpuIntr_o` pulse; CS_n_o sequence 2'b10, 2'b11 (≥4 cycles), 2'b01.
- Threshold=16, second scan ch0=16'h0C88 (d=8), ch1=16'h0D11 (d=17) -> only ch1 updated, `IrqChannels_o`=2'b10.
- Equal value, d=Threshold -> no update, no IRQ; d=Threshold+1 -> IRQ.
- Hold `SPI_FIFOFull_i`=1 for 10 cycles during Send -> no `SPI_Write_o` while full; exactly 3 pushes (8'h50, 8'hFF, 8'hFF) per channel.
- Drop `Enable_i` in Drain -> CS_n all high next cycle, RX FIFO popped until empty, state Disabled, `SensorValue_o` unchanged.
- With `SPI_POLLER_IRQ_STATUS_EN`: ch1 fires, then `IrqClear_i`=2'b10 is asserted in the same cycle as a new ch1 fire -> `IrqStatus_o[1]` stays 1.
